// File: rtl/pipe_stage_buf.sv
// Elastic inter-stage register: DEPTH-entry valid/ready buffer with exception merge, PC-carrying bubbles and flush.
// Head is visible with zero latency; in_ready = not-full OR out_ready, so a full buffer still sustains one entry per cycle.
module pipe_stage_buf #(
  parameter int              DATA_W     = 128,
  parameter int              PC_W       = 32,
  parameter int              EXC_W      = 5,
  parameter int              DEPTH      = 2,
  parameter logic [PC_W-1:0] RESET_PC   = 32'h0000_0000,
  parameter logic [PC_W-1:0] HANDLER_PC = 32'h0000_4180,
  parameter int              CNT_W      = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PC_W-1:0]            in_pc,
  input  logic [31:0]                in_instr,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [EXC_W-1:0]           in_exc,
  input  logic [EXC_W-1:0]           in_cu_exc,
  input  logic                       in_isdb,
  input  logic                       in_branch,
  input  logic                       stall,
  input  logic                       int_req,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_W-1:0]            out_pc,
  output logic [31:0]                out_instr,
  output logic [DATA_W-1:0]          out_data,
  output logic [EXC_W-1:0]           out_exc,
  output logic                       out_isdb,
  output logic                       out_branch,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [CNT_W-1:0]           bubble_cnt
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [31:0]       instr;
    logic [DATA_W-1:0] data;
    logic [EXC_W-1:0]  exc;
    logic              isdb;
    logic              branch;
  } entry_t;

  entry_t            mem_q [DEPTH];
  entry_t            in_entry;
  entry_t            head;

  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PC_W-1:0]   bub_pc_q, bub_pc_d;
  logic              bub_isdb_q, bub_isdb_d;
  logic [CNT_W-1:0]  bub_cnt_q, bub_cnt_d;

  logic              push;
  logic              pop;
  logic              cu_hit;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign out_valid = (count_q != '0);
  assign in_ready  = (count_q < CW'(DEPTH)) | out_ready;
  assign push      = in_valid & in_ready & ~stall & ~int_req;
  assign pop       = out_valid & out_ready & ~int_req;

  // A decoder-raised exception overrides the inherited code and kills the instruction word.
  assign cu_hit = (in_cu_exc != '0);

  always_comb begin
    in_entry        = '0;
    in_entry.pc     = in_pc;
    in_entry.instr  = cu_hit ? 32'd0 : in_instr;
    in_entry.data   = in_data;
    in_entry.exc    = cu_hit ? in_cu_exc : in_exc;
    in_entry.isdb   = in_isdb;
    in_entry.branch = in_branch;
  end

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    bub_pc_d   = bub_pc_q;
    bub_isdb_d = bub_isdb_q;
    if (int_req) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      bub_pc_d   = HANDLER_PC;
      bub_isdb_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      // A stalled slot keeps its EPC and delay-slot status for precise exceptions.
      if (stall && in_valid) begin
        bub_pc_d   = in_pc;
        bub_isdb_d = in_isdb;
      end
    end
  end

  always_comb begin
    bub_cnt_d = bub_cnt_q;
    if (!out_valid && (bub_cnt_q != '1)) bub_cnt_d = bub_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      bub_pc_q   <= RESET_PC;
      bub_isdb_q <= 1'b0;
      bub_cnt_q  <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      bub_pc_q   <= bub_pc_d;
      bub_isdb_q <= bub_isdb_d;
      bub_cnt_q  <= bub_cnt_d;
    end
  end

  // Storage is never reset; out_valid masks stale contents.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_entry;
  end

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    out_pc     = bub_pc_q;
    out_instr  = 32'd0;
    out_data   = '0;
    out_exc    = '0;
    out_isdb   = bub_isdb_q;
    out_branch = 1'b0;
    if (out_valid) begin
      out_pc     = head.pc;
      out_instr  = head.instr;
      out_data   = head.data;
      out_exc    = head.exc;
      out_isdb   = head.isdb;
      out_branch = head.branch;
    end
  end

  assign count      = count_q;
  assign bubble_cnt = bub_cnt_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf (DEPTH=2, CNT_W=4) with hand-computed expectations.
module tb_pipe_stage_buf;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_pc;
  logic [31:0]  in_instr;
  logic [127:0] in_data;
  logic [4:0]   in_exc;
  logic [4:0]   in_cu_exc;
  logic         in_isdb;
  logic         in_branch;
  logic         stall;
  logic         int_req;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_pc;
  logic [31:0]  out_instr;
  logic [127:0] out_data;
  logic [4:0]   out_exc;
  logic         out_isdb;
  logic         out_branch;
  logic [1:0]   count;
  logic [3:0]   bubble_cnt;

  int n_chk = 0;
  int n_bad = 0;

  pipe_stage_buf #(.DEPTH(2), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .in_data(in_data), .in_exc(in_exc), .in_cu_exc(in_cu_exc), .in_isdb(in_isdb),
    .in_branch(in_branch), .stall(stall), .int_req(int_req),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .out_data(out_data), .out_exc(out_exc), .out_isdb(out_isdb), .out_branch(out_branch),
    .count(count), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; in_data = '0;
    in_exc = '0; in_cu_exc = '0; in_isdb = 1'b0; in_branch = 1'b0;
    stall = 1'b0; int_req = 1'b0; out_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    n_chk++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got=%0d exp=0", out_valid); end
    n_chk++; if (out_pc !== 32'h0) begin n_bad++; $display("FAIL rst_pc got=%h exp=00000000", out_pc); end
    n_chk++; if (out_instr !== 32'h0) begin n_bad++; $display("FAIL rst_instr got=%h exp=0", out_instr); end
    n_chk++; if (out_data !== 128'h0) begin n_bad++; $display("FAIL rst_data got=%h exp=0", out_data); end
    n_chk++; if (out_exc !== 5'd0) begin n_bad++; $display("FAIL rst_exc got=%0d exp=0", out_exc); end
    n_chk++; if (out_isdb !== 1'b0) begin n_bad++; $display("FAIL rst_isdb got=%0d exp=0", out_isdb); end
    n_chk++; if (out_branch !== 1'b0) begin n_bad++; $display("FAIL rst_branch got=%0d exp=0", out_branch); end
    n_chk++; if (count !== 2'd0) begin n_bad++; $display("FAIL rst_count got=%0d exp=0", count); end
    n_chk++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready got=%0d exp=1", in_ready); end
    n_chk++; if (bubble_cnt !== 4'd0) begin n_bad++; $display("FAIL rst_bubble got=%0d exp=0", bubble_cnt); end
    reset = 1'b0;
  endtask

  task automatic test_push();
    in_valid = 1'b1; in_pc = 32'h3000; in_instr = 32'h2401_0001;
    in_data = {96'd0, 32'hD0D0_0001}; in_exc = 5'd0; in_cu_exc = 5'd0; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    n_chk++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL push_valid got=%0d exp=1", out_valid); end
    n_chk++; if (out_pc !== 32'h3000) begin n_bad++; $display("FAIL push_pc got=%h exp=00003000", out_pc); end
    n_chk++; if (out_instr !== 32'h2401_0001) begin n_bad++; $display("FAIL push_instr got=%h exp=24010001", out_instr); end
    n_chk++; if (out_data !== {96'd0, 32'hD0D0_0001}) begin n_bad++; $display("FAIL push_data got=%h exp=d0d00001", out_data); end
    n_chk++; if (count !== 2'd1) begin n_bad++; $display("FAIL push_count got=%0d exp=1", count); end
    n_chk++; if (bubble_cnt !== 4'd1) begin n_bad++; $display("FAIL push_bubble got=%0d exp=1", bubble_cnt); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_chk++; if (count !== 2'd0) begin n_bad++; $display("FAIL pop_count got=%0d exp=0", count); end
    n_chk++; if (out_pc !== 32'h0) begin n_bad++; $display("FAIL pop_bubble_pc got=%h exp=00000000", out_pc); end
    n_chk++; if (bubble_cnt !== 4'd1) begin n_bad++; $display("FAIL pop_bubble got=%0d exp=1", bubble_cnt); end
  endtask

  task automatic test_exc_merge();
    in_valid = 1'b1; in_pc = 32'h3004; in_instr = 32'h8C22_0004;
    in_exc = 5'd4; in_cu_exc = 5'd10; out_ready = 1'b0;
    tick();
    n_chk++; if (out_exc !== 5'd10) begin n_bad++; $display("FAIL merge_cu_exc got=%0d exp=10", out_exc); end
    n_chk++; if (out_instr !== 32'h0) begin n_bad++; $display("FAIL merge_cu_instr got=%h exp=0", out_instr); end
    n_chk++; if (out_pc !== 32'h3004) begin n_bad++; $display("FAIL merge_cu_pc got=%h exp=00003004", out_pc); end
    in_pc = 32'h3008; in_instr = 32'hAC23_0008; in_exc = 5'd4; in_cu_exc = 5'd0;
    in_branch = 1'b1; out_ready = 1'b1;
    tick();
    n_chk++; if (count !== 2'd1) begin n_bad++; $display("FAIL merge_pp_count got=%0d exp=1", count); end
    n_chk++; if (out_exc !== 5'd4) begin n_bad++; $display("FAIL merge_in_exc got=%0d exp=4", out_exc); end
    n_chk++; if (out_instr !== 32'hAC23_0008) begin n_bad++; $display("FAIL merge_in_instr got=%h exp=ac230008", out_instr); end
    n_chk++; if (out_branch !== 1'b1) begin n_bad++; $display("FAIL merge_branch got=%0d exp=1", out_branch); end
    in_valid = 1'b0; in_branch = 1'b0; in_exc = 5'd0;
    tick();
    out_ready = 1'b0;
    n_chk++; if (count !== 2'd0) begin n_bad++; $display("FAIL merge_drain got=%0d exp=0", count); end
    n_chk++; if (out_branch !== 1'b0) begin n_bad++; $display("FAIL empty_branch got=%0d exp=0", out_branch); end
    n_chk++; if (out_exc !== 5'd0) begin n_bad++; $display("FAIL empty_exc got=%0d exp=0", out_exc); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    in_valid = 1'b1; in_pc = 32'h3100; in_instr = 32'h1111_1111;
    tick();
    in_pc = 32'h3104; in_instr = 32'h2222_2222;
    tick();
    n_chk++; if (count !== 2'd2) begin n_bad++; $display("FAIL full_count got=%0d exp=2", count); end
    n_chk++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL full_in_ready got=%0d exp=0", in_ready); end
    in_pc = 32'h310C; in_instr = 32'hEEEE_EEEE;
    tick();
    n_chk++; if (count !== 2'd2) begin n_bad++; $display("FAIL full_hold_count got=%0d exp=2", count); end
    n_chk++; if (out_pc !== 32'h3100) begin n_bad++; $display("FAIL full_hold_head got=%h exp=00003100", out_pc); end
    in_pc = 32'h3108; in_instr = 32'h3333_3333; out_ready = 1'b1;
    #1;
    n_chk++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL full_passthru_rdy got=%0d exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_chk++; if (count !== 2'd2) begin n_bad++; $display("FAIL wrap_count got=%0d exp=2", count); end
    n_chk++; if (out_pc !== 32'h3104) begin n_bad++; $display("FAIL wrap_head_b got=%h exp=00003104", out_pc); end
    tick();
    n_chk++; if (out_pc !== 32'h3108) begin n_bad++; $display("FAIL wrap_head_c got=%h exp=00003108", out_pc); end
    n_chk++; if (out_instr !== 32'h3333_3333) begin n_bad++; $display("FAIL wrap_instr_c got=%h exp=33333333", out_instr); end
    n_chk++; if (count !== 2'd1) begin n_bad++; $display("FAIL wrap_count1 got=%0d exp=1", count); end
    tick();
    out_ready = 1'b0;
    n_chk++; if (count !== 2'd0) begin n_bad++; $display("FAIL wrap_drain got=%0d exp=0", count); end
  endtask

  task automatic test_stall();
    do_reset();
    stall = 1'b1; in_valid = 1'b1; in_pc = 32'h3010; in_isdb = 1'b1; in_instr = 32'hDEAD_BEEF;
    tick();
    n_chk++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stall_valid got=%0d exp=0", out_valid); end
    n_chk++; if (count !== 2'd0) begin n_bad++; $display("FAIL stall_count got=%0d exp=0", count); end
    n_chk++; if (out_pc !== 32'h3010) begin n_bad++; $display("FAIL stall_pc got=%h exp=00003010", out_pc); end
    n_chk++; if (out_isdb !== 1'b1) begin n_bad++; $display("FAIL stall_isdb got=%0d exp=1", out_isdb); end
    n_chk++; if (out_instr !== 32'h0) begin n_bad++; $display("FAIL stall_instr got=%h exp=0", out_instr); end
    n_chk++; if (bubble_cnt !== 4'd1) begin n_bad++; $display("FAIL stall_bubble got=%0d exp=1", bubble_cnt); end
    stall = 1'b0; in_pc = 32'h3014; in_isdb = 1'b0;
    tick();
    n_chk++; if (count !== 2'd1) begin n_bad++; $display("FAIL stall_push_count got=%0d exp=1", count); end
    n_chk++; if (out_pc !== 32'h3014) begin n_bad++; $display("FAIL stall_push_pc got=%h exp=00003014", out_pc); end
    stall = 1'b1; in_pc = 32'h3018; in_isdb = 1'b1; out_ready = 1'b1;
    tick();
    n_chk++; if (count !== 2'd0) begin n_bad++; $display("FAIL stall_drain_count got=%0d exp=0", count); end
    n_chk++; if (out_pc !== 32'h3018) begin n_bad++; $display("FAIL stall_drain_pc got=%h exp=00003018", out_pc); end
    n_chk++; if (out_isdb !== 1'b1) begin n_bad++; $display("FAIL stall_drain_isdb got=%0d exp=1", out_isdb); end
    n_chk++; if (bubble_cnt !== 4'd2) begin n_bad++; $display("FAIL stall_drain_bubble got=%0d exp=2", bubble_cnt); end
    idle_inputs();
  endtask

  task automatic test_flush();
    do_reset();
    stall = 1'b1; in_valid = 1'b1; in_pc = 32'h3020; in_isdb = 1'b1;
    tick();
    stall = 1'b0; in_isdb = 1'b0; in_pc = 32'h3200;
    tick();
    in_pc = 32'h3204;
    tick();
    n_chk++; if (count !== 2'd2) begin n_bad++; $display("FAIL flush_fill got=%0d exp=2", count); end
    int_req = 1'b1; in_pc = 32'h3208; out_ready = 1'b1;
    tick();
    int_req = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    n_chk++; if (count !== 2'd0) begin n_bad++; $display("FAIL flush_count got=%0d exp=0", count); end
    n_chk++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid got=%0d exp=0", out_valid); end
    n_chk++; if (out_pc !== 32'h4180) begin n_bad++; $display("FAIL flush_pc got=%h exp=00004180", out_pc); end
    n_chk++; if (out_isdb !== 1'b0) begin n_bad++; $display("FAIL flush_isdb got=%0d exp=0", out_isdb); end
    tick();
    n_chk++; if (count !== 2'd0) begin n_bad++; $display("FAIL flush_nopush got=%0d exp=0", count); end
    in_valid = 1'b1; in_pc = 32'h3300; in_instr = 32'h4444_4444;
    tick();
    in_valid = 1'b0;
    n_chk++; if (out_pc !== 32'h3300) begin n_bad++; $display("FAIL flush_repush_pc got=%h exp=00003300", out_pc); end
    n_chk++; if (count !== 2'd1) begin n_bad++; $display("FAIL flush_repush_count got=%0d exp=1", count); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    stall = 1'b1; int_req = 1'b1; in_valid = 1'b1; in_pc = 32'h3030;
    tick();
    n_chk++; if (out_pc !== 32'h4180) begin n_bad++; $display("FAIL flush_over_stall got=%h exp=00004180", out_pc); end
    int_req = 1'b0; reset = 1'b1; in_pc = 32'h5000;
    tick();
    n_chk++; if (out_pc !== 32'h0) begin n_bad++; $display("FAIL reset_over_stall got=%h exp=00000000", out_pc); end
    n_chk++; if (count !== 2'd0) begin n_bad++; $display("FAIL reset_over_stall_cnt got=%0d exp=0", count); end
    idle_inputs();
  endtask

  task automatic test_bubble_sat();
    do_reset();
    repeat (14) tick();
    n_chk++; if (bubble_cnt !== 4'd14) begin n_bad++; $display("FAIL bubble_14 got=%0d exp=14", bubble_cnt); end
    repeat (6) tick();
    n_chk++; if (bubble_cnt !== 4'd15) begin n_bad++; $display("FAIL bubble_sat got=%0d exp=15", bubble_cnt); end
    int_req = 1'b1;
    tick();
    int_req = 1'b0;
    n_chk++; if (bubble_cnt !== 4'd15) begin n_bad++; $display("FAIL bubble_int got=%0d exp=15", bubble_cnt); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_chk++; if (bubble_cnt !== 4'd0) begin n_bad++; $display("FAIL bubble_rst got=%0d exp=0", bubble_cnt); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_push();
    test_exc_merge();
    test_back_to_back();
    test_stall();
    test_flush();
    test_bubble_sat();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
Parametrised elastic inter-stage register for the pipelined CPU. It generalises the fixed D->E latch into a DEPTH-entry buffer with a valid/ready handshake, a generic payload width, exception-code merge, stall bubbles that carry the PC, and interrupt flush. It sits between any two pipeline stages (D->E, E->M, M->W) and keeps per-stage bubble statistics.

Parameters:
DATA_W, 128, width of the opaque payload (operands, immediates, results)
PC_W, 32, PC width
EXC_W, 5, exception-code width
DEPTH, 2, buffer entries; must be at least 1
RESET_PC, 32'h0000_0000, bubble PC after reset
HANDLER_PC, 32'h0000_4180, bubble PC after an interrupt flush
CNT_W, 16, width of the bubble counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  upstream entry present
in_ready  out  1  buffer can accept this cycle
in_pc  in  PC_W  upstream PC
in_instr  in  32  upstream instruction
in_data  in  DATA_W  upstream payload
in_exc  in  EXC_W  exception code carried from earlier stages
in_cu_exc  in  EXC_W  exception code raised by this stage's decoder
in_isdb  in  1  in a branch delay slot
in_branch  in  1  instruction is a branch/jump
stall  in  1  hazard hold: upstream must not advance, so a bubble is inserted
int_req  in  1  interrupt/exception flush
out_valid  out  1  head entry valid
out_ready  in  1  downstream consumes head
out_pc  out  PC_W  head PC, or bubble PC when empty
out_instr  out  32  head instruction; 0 when empty
out_data  out  DATA_W  head payload; 0 when empty
out_exc  out  EXC_W  head exception code; 0 when empty
out_isdb  out  1  head isdb, or bubble isdb when empty
out_branch  out  1  head branch flag; 0 when empty
count  out  $clog2(DEPTH+1)  occupied entries
bubble_cnt  out  CNT_W  saturating count of cycles with out_valid=0

Behaviour:
- Storage: circular buffer with rd_ptr/wr_ptr that wrap modulo DEPTH, plus count. The bubble-PC and bubble-isdb registers are held separately.
- push = in_valid & in_ready & ~stall & ~int_req.
- pop = out_valid & out_ready & ~int_req.
- in_ready = (count < DEPTH) | out_ready. This is a combinational out_ready->in_ready path, needed only when full, so DEPTH=1 still sustains 1 entry/cycle.
- Push and pop in the same cycle: count unchanged, both pointers advance. This also applies when full, since in_ready is high through out_ready.
- Merge on push:
  - stored exc = (in_cu_exc != 0) ? in_cu_exc : in_exc.
  - stored instr = (in_cu_exc != 0) ? 0 : in_instr.
  - pc, data, isdb and branch are stored unchanged.
- Outputs with count > 0: out_valid=1, all fields from the head entry. Zero latency from the stored head.
- Outputs with count == 0: out_valid=0, out_instr=0, out_data=0, out_exc=0, out_branch=0. out_pc and out_isdb come from the bubble registers.
- Bubble registers:
  - On stall & in_valid & ~int_req: load in_pc and in_isdb, so a stalled slot keeps its EPC and delay-slot status.
  - Otherwise they hold their value.
- Priority: reset > int_req > stall > normal.
- int_req:
  - Next cycle: count=0, pointers=0.
  - Bubble PC = HANDLER_PC, bubble isdb = 0.
  - No push or pop occurs in the flush cycle, even if in_valid or out_ready is high.
- stall: no push. Pop continues normally, so the buffer drains toward a bubble.
- bubble_cnt: increments on every cycle with out_valid=0 and saturates at all-ones. It is cleared only by reset and is not cleared by int_req.
- Reset (synchronous): count=0, pointers=0, bubble PC=RESET_PC, bubble isdb=0, bubble_cnt=0. Storage contents are don't-care and must not reach the outputs.
  - Output values after reset: out_valid=0, out_pc=RESET_PC, all other data outputs 0, in_ready=1.
- Reset or int_req asserted mid-operation drops all entries. No partial entry survives.

Test Plan:
1. Reset, then push pc=0x3000, instr=0x24010001, in_exc=0, in_cu_exc=0 with out_ready=0 -> next cycle out_valid=1, out_pc=0x3000, out_instr=0x24010001, count=1.
2. Push with in_exc=4, in_cu_exc=10 -> stored exc=10, out_instr=0. Push with in_exc=4, in_cu_exc=0 -> exc=4, instr preserved.
3. DEPTH=2: push A and B with out_ready=0 -> count=2, in_ready=0. Then raise out_ready with in_valid high carrying C -> A pops and C pushes, count stays 2, wr_ptr wraps to 0, order B then C.
4. Buffer empty; stall=1, in_valid=1, in_pc=0x3010, in_isdb=1 -> next cycle out_valid=0, out_pc=0x3010, out_isdb=1, out_instr=0, bubble_cnt increments.
5. Full buffer; int_req=1 with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, out_pc=0x4180, out_isdb=0, nothing pushed or popped; reset and stall raised in the same cycle -> out_pc=RESET_PC.
6. CNT_W=4, hold empty for 20 cycles -> bubble_cnt saturates at 15. Then int_req -> bubble_cnt stays 15. Then reset -> bubble_cnt=0.
